// File: rtl/pipe_stage_buf_pkg.sv
// Shared RISC-V pipeline types: control vector layout and stage-buffer occupancy states.
package riscv_types;

    // An all-zero control vector is a NOP; bubbles rely on this.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
    } riscv_control_t;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_BUSY,
        PS_FULL
    } pipe_state_t;

    localparam int CTRL_W_DEF = $bits(riscv_control_t);

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter: counts inc_in cycles, holds at all-ones, cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             inc_in,
    output logic [CNT_W-1:0] count_out
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_out <= '0;
        end else if (inc_in && (count_out != '1)) begin
            count_out <= count_out + ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, optional skid entry,
// flush, NOP masking of the control vector while empty, and performance counters.
module pipe_stage_buf
    import riscv_types::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              up_valid_in,
    input  logic [DATA_W-1:0] up_data_in,
    input  logic [CTRL_W-1:0] up_ctrl_in,
    output logic              up_ready_out,
    output logic              dn_valid_out,
    output logic [DATA_W-1:0] dn_data_out,
    output logic [CTRL_W-1:0] dn_ctrl_out,
    input  logic              dn_ready_in,
    input  logic              flush_in,
    output logic [CNT_W-1:0]  stall_cnt_out,
    output logic [CNT_W-1:0]  xfer_cnt_out
);

    pipe_state_t       state, state_nxt;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              up_xfer, dn_xfer;
    logic              load_main, main_from_skid, load_skid;

    assign dn_valid_out = (state != PS_EMPTY);
    assign up_xfer      = up_valid_in & up_ready_out;
    assign dn_xfer      = dn_valid_out & dn_ready_in;

    generate
        if (SKID != 0) begin : g_ready_reg
            assign up_ready_out = (state != PS_FULL);
        end else begin : g_ready_comb
            assign up_ready_out = dn_ready_in | ~dn_valid_out;
        end
    endgenerate

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_in) begin
            state_nxt = PS_EMPTY;
        end else begin
            unique case (state)
                PS_EMPTY: begin
                    if (up_xfer) begin
                        state_nxt = PS_BUSY;
                        load_main = 1'b1;
                    end
                end
                PS_BUSY: begin
                    if (up_xfer && dn_xfer) begin
                        load_main = 1'b1;
                    end else if (dn_xfer) begin
                        state_nxt = PS_EMPTY;
                    end else if (up_xfer && (SKID != 0)) begin
                        state_nxt = PS_FULL;
                        load_skid = 1'b1;
                    end
                end
                PS_FULL: begin
                    if (dn_xfer) begin
                        state_nxt      = PS_BUSY;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= PS_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_data <= main_from_skid ? skid_data : up_data_in;
                main_ctrl <= main_from_skid ? skid_ctrl : up_ctrl_in;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    skid_data <= '0;
                    skid_ctrl <= '0;
                end else if (load_skid) begin
                    skid_data <= up_data_in;
                    skid_ctrl <= up_ctrl_in;
                end
            end
        end else begin : g_no_skid
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    assign dn_data_out = main_data;
    assign dn_ctrl_out = dn_valid_out ? main_ctrl : '0;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (dn_valid_out & ~dn_ready_in),
        .count_out (stall_cnt_out)
    );

    sat_counter #(.CNT_W(CNT_W)) u_xfer_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .inc_in    (dn_xfer),
        .count_out (xfer_cnt_out)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: instance 0 uses the skid buffer (16-bit counters),
// instance 1 is the single-register variant with 4-bit counters.
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst      [2];
    logic        up_valid [2];
    logic [31:0] up_data  [2];
    logic [10:0] up_ctrl  [2];
    logic        up_ready [2];
    logic        dn_valid [2];
    logic [31:0] dn_data  [2];
    logic [10:0] dn_ctrl  [2];
    logic        dn_ready [2];
    logic        flush    [2];
    logic [15:0] stall_a, xfer_a;
    logic [3:0]  stall_b, xfer_b;

    int errors = 0;
    int checks = 0;

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(11), .SKID(1), .CNT_W(16)) dut_skid (
        .clk_in(clk), .rst_in(rst[0]),
        .up_valid_in(up_valid[0]), .up_data_in(up_data[0]), .up_ctrl_in(up_ctrl[0]),
        .up_ready_out(up_ready[0]),
        .dn_valid_out(dn_valid[0]), .dn_data_out(dn_data[0]), .dn_ctrl_out(dn_ctrl[0]),
        .dn_ready_in(dn_ready[0]), .flush_in(flush[0]),
        .stall_cnt_out(stall_a), .xfer_cnt_out(xfer_a)
    );

    pipe_stage_buf #(.DATA_W(32), .CTRL_W(11), .SKID(0), .CNT_W(4)) dut_reg (
        .clk_in(clk), .rst_in(rst[1]),
        .up_valid_in(up_valid[1]), .up_data_in(up_data[1]), .up_ctrl_in(up_ctrl[1]),
        .up_ready_out(up_ready[1]),
        .dn_valid_out(dn_valid[1]), .dn_data_out(dn_data[1]), .dn_ctrl_out(dn_ctrl[1]),
        .dn_ready_in(dn_ready[1]), .flush_in(flush[1]),
        .stall_cnt_out(stall_b), .xfer_cnt_out(xfer_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each stage is an in-order FIFO of accepted words, capacity 2 with
    // the skid entry and 1 otherwise; flush empties it. Counters are saturating tallies.
    logic [42:0] sbq0 [$];
    logic [42:0] sbq1 [$];
    int          stall_m [2];
    int          xfer_m  [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int          sz;
            int          cmax;
            logic [42:0] head;
            logic        mv, er;
            longint unsigned st_act, xf_act;
            cmax = (i == 0) ? 65535 : 15;
            if (!rst[i]) begin
                if (i == 0) sbq0.delete(); else sbq1.delete();
                stall_m[i] = 0;
                xfer_m[i]  = 0;
            end else begin
                sz   = (i == 0) ? sbq0.size() : sbq1.size();
                head = (sz == 0) ? '0 : ((i == 0) ? sbq0[0] : sbq1[0]);
                mv   = (sz > 0);
                er   = (i == 0) ? (sz < 2) : (dn_ready[i] | ~mv);
                st_act = (i == 0) ? longint'(stall_a) : longint'(stall_b);
                xf_act = (i == 0) ? longint'(xfer_a)  : longint'(xfer_b);
                check($sformatf("dut%0d dn_valid", i), dn_valid[i], mv);
                check($sformatf("dut%0d up_ready", i), up_ready[i], er);
                if (mv) begin
                    check($sformatf("dut%0d dn_data", i), dn_data[i], head[42:11]);
                    check($sformatf("dut%0d dn_ctrl", i), dn_ctrl[i], head[10:0]);
                end else begin
                    check($sformatf("dut%0d bubble ctrl", i), dn_ctrl[i], 0);
                end
                check($sformatf("dut%0d stall_cnt", i), st_act, stall_m[i]);
                check($sformatf("dut%0d xfer_cnt", i), xf_act, xfer_m[i]);
                if (mv && !dn_ready[i] && stall_m[i] < cmax) stall_m[i]++;
                if (mv && dn_ready[i]) begin
                    if (xfer_m[i] < cmax) xfer_m[i]++;
                    if (i == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
                end
                if (flush[i]) begin
                    if (i == 0) sbq0.delete(); else sbq1.delete();
                end else if (up_valid[i] && er) begin
                    if (i == 0) sbq0.push_back({up_data[i], up_ctrl[i]});
                    else        sbq1.push_back({up_data[i], up_ctrl[i]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int i);
        rst[i] = 1'b0;
        tick();
        rst[i] = 1'b1;
    endtask

    task automatic offer(input int i, input logic [31:0] d, input logic [10:0] c);
        up_valid[i] = 1'b1;
        up_data[i]  = d;
        up_ctrl[i]  = c;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; up_valid[i] = 1'b0; up_data[i] = '0; up_ctrl[i] = '0;
            dn_ready[i] = 1'b0; flush[i] = 1'b0;
        end
        #3;
        check("reset dn_valid", dn_valid[0], 0);
        check("reset dn_data", dn_data[0], 0);
        check("reset dn_ctrl", dn_ctrl[0], 0);
        check("reset up_ready", up_ready[0], 1);
        check("reset stall_cnt", stall_a, 0);
        check("reset xfer_cnt", xfer_a, 0);
        tick();
        tick();
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // Reset asserted between edges while a word is held
        offer(0, 32'hDEADBEEF, 11'h155);
        tick();
        up_valid[0] = 1'b0;
        check("load dn_valid", dn_valid[0], 1);
        check("load dn_data", dn_data[0], 32'hDEADBEEF);
        #1 rst[0] = 1'b0;
        #1;
        check("midreset dn_valid", dn_valid[0], 0);
        check("midreset dn_ctrl", dn_ctrl[0], 0);
        check("midreset up_ready", up_ready[0], 1);
        check("midreset stall_cnt", stall_a, 0);
        check("midreset xfer_cnt", xfer_a, 0);
        tick();
        rst[0] = 1'b1;

        // Streaming with dn_ready=1
        dn_ready[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            offer(0, 32'(k), 11'(k));
            tick();
            check($sformatf("stream word %0d", k), dn_data[0], k);
            check($sformatf("stream valid %0d", k), dn_valid[0], 1);
        end
        up_valid[0] = 1'b0;
        tick();
        check("stream drained", dn_valid[0], 0);
        check("stream xfer_cnt", xfer_a, 3);
        check("stream stall_cnt", stall_a, 0);

        // Backpressure through the skid entry
        reset_dut(0);
        dn_ready[0] = 1'b0;
        offer(0, 32'hAAAA0001, 11'h001);
        check("bp ready empty", up_ready[0], 1);
        tick();
        check("bp A shown", dn_data[0], 32'hAAAA0001);
        check("bp ready busy", up_ready[0], 1);
        offer(0, 32'hBBBB0002, 11'h002);
        tick();
        check("bp A held", dn_data[0], 32'hAAAA0001);
        check("bp ready full", up_ready[0], 0);
        offer(0, 32'hCCCC0003, 11'h003);
        tick();
        tick();
        check("bp A still held", dn_data[0], 32'hAAAA0001);
        check("bp ready still full", up_ready[0], 0);
        dn_ready[0] = 1'b1;
        tick();
        check("bp B second", dn_data[0], 32'hBBBB0002);
        check("bp ready reopened", up_ready[0], 1);
        tick();
        check("bp C third", dn_data[0], 32'hCCCC0003);
        up_valid[0] = 1'b0;
        tick();
        check("bp drained", dn_valid[0], 0);
        check("bp stall_cnt", stall_a, 3);
        check("bp xfer_cnt", xfer_a, 3);

        // Flush while FULL, with an upstream word offered
        dn_ready[0] = 1'b0;
        offer(0, 32'hD0D0D0D0, 11'h011);
        tick();
        offer(0, 32'hE0E0E0E0, 11'h022);
        tick();
        offer(0, 32'hF0F0F0F0, 11'h7FF);
        flush[0] = 1'b1;
        check("flush pre ready", up_ready[0], 0);
        tick();
        flush[0] = 1'b0;
        up_valid[0] = 1'b0;
        check("flush dn_valid", dn_valid[0], 0);
        check("flush dn_ctrl", dn_ctrl[0], 0);
        check("flush up_ready", up_ready[0], 1);
        dn_ready[0] = 1'b1;
        tick();
        tick();
        check("flush word gone", dn_valid[0], 0);
        check("flush xfer_cnt kept", xfer_a, 3);

        // Flush in BUSY: outgoing word still counts, incoming word discarded
        offer(0, 32'h12345678, 11'h0F0);
        tick();
        offer(0, 32'h9ABCDEF0, 11'h70F);
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        up_valid[0] = 1'b0;
        check("flush busy dn_valid", dn_valid[0], 0);
        check("flush busy xfer_cnt", xfer_a, 4);
        tick();
        check("flush busy no leak", dn_valid[0], 0);

        // Random traffic on the skid instance
        for (int n = 0; n < 300; n++) begin
            up_valid[0] = 1'($urandom);
            up_data[0]  = $urandom;
            up_ctrl[0]  = 11'($urandom);
            dn_ready[0] = ($urandom_range(0, 3) != 0);
            flush[0]    = ($urandom_range(0, 15) == 0);
            tick();
        end
        up_valid[0] = 1'b0;
        flush[0]    = 1'b0;
        dn_ready[0] = 1'b1;
        repeat (4) tick();
        check("random skid drained", dn_valid[0], 0);

        // Counter saturation on the 4-bit instance
        reset_dut(1);
        dn_ready[1] = 1'b0;
        offer(1, 32'h5A5A5A5A, 11'h3C3);
        tick();
        up_valid[1] = 1'b0;
        repeat (20) tick();
        check("sat stall_cnt", stall_b, 15);
        tick();
        check("sat stall_cnt held", stall_b, 15);
        check("sat word held", dn_data[1], 32'h5A5A5A5A);

        // Random traffic on the single-register instance
        reset_dut(1);
        for (int n = 0; n < 200; n++) begin
            up_valid[1] = 1'($urandom);
            up_data[1]  = $urandom;
            up_ctrl[1]  = 11'($urandom);
            dn_ready[1] = 1'($urandom);
            tick();
        end
        up_valid[1] = 1'b0;
        dn_ready[1] = 1'b1;
        repeat (3) tick();
        check("random reg drained", dn_valid[1], 0);
        check("random reg xfer saturated", xfer_b, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline stage register for the RISC-V core. It is the successor to the fixed inter-stage latches, and a single instance type covers IF/ID, ID/EX, EX/MEM and MEM/WB.
- Adds a valid/ready handshake, an optional 2-entry skid buffer so the ready path is registered, synchronous flush, and bubble control-zeroing.
- Adds saturating stall and transfer counters for performance monitoring.
- Everything runs on a single rising clock edge. There is no negedge output copy.

Parameters:
DATA_W, 32, width of the datapath payload (pc, operands, immediates, packed by the instantiating stage).
CTRL_W, 11, width of the control vector. Normally $bits(riscv_control_t).
SKID, 1, selects the buffering mode. 1 = two-entry skid buffer with registered up_ready_out. 0 = single register with combinational ready.
CNT_W, 16, width of each performance counter.

Ports:
clk_in  in  1  clock, rising edge.
rst_in  in  1  reset, asynchronous, active-low.
up_valid_in  in  1  upstream word valid.
up_data_in  in  DATA_W  upstream payload.
up_ctrl_in  in  CTRL_W  upstream control vector.
up_ready_out  out  1  stage can accept a word this cycle.
dn_valid_out  out  1  output word valid.
dn_data_out  out  DATA_W  output payload.
dn_ctrl_out  out  CTRL_W  output control vector. Forced to 0 when dn_valid_out=0.
dn_ready_in  in  1  downstream accepts the word.
flush_in  in  1  discard all held words (branch/exception kill).
stall_cnt_out  out  CNT_W  cycles with dn_valid_out=1 and dn_ready_in=0.
xfer_cnt_out  out  CNT_W  completed downstream transfers.

Behaviour:
Reset (async, while rst_in=0):
- State is EMPTY.
- dn_valid_out=0; dn_data_out and dn_ctrl_out are 0; both counters are 0.
- up_ready_out=1.
- Entries loaded on the rising edge following reset deassertion are accepted normally.

Handshake rules:
- An upstream transfer occurs when up_valid_in & up_ready_out. A downstream transfer occurs when dn_valid_out & dn_ready_in.
- Latency: a word accepted at edge N is visible on dn_* after edge N, with zero bubbles in streaming.
- Words leave in acceptance order, with no loss and no duplication.

States (SKID=1): EMPTY, BUSY (main register holds a word), FULL (main and skid both hold a word).
- EMPTY: up transfer -> BUSY, word loaded into main.
- BUSY:
  - up & dn transfer -> BUSY, main replaced.
  - dn only -> EMPTY.
  - up only -> FULL, word loaded into skid.
- FULL: up_ready_out=0. A dn transfer moves skid to main -> BUSY.
- up_ready_out = (state != FULL). It is a registered state decode with no combinational path from dn_ready_in.

SKID=0 mode:
- The FULL state is unreachable and the skid storage is not built.
- up_ready_out = dn_ready_in | ~dn_valid_out (combinational).

Flush:
- flush_in has the highest priority. On the next edge the state becomes EMPTY, dn_valid_out=0 and dn_ctrl_out=0.
- An upstream word handshaking in the flush cycle is consumed and discarded.
- A downstream transfer in the flush cycle still counts in xfer_cnt_out.
- dn_data_out is don't-care while invalid. The implementation keeps the old value.

Bubble zeroing:
- dn_ctrl_out is combinationally masked to all-zero when dn_valid_out=0, so later stages see a NOP control vector.

Counters:
- Each counter increments by 1 per qualifying cycle and saturates at all-ones, with no wrap.
- Counters are cleared only by reset, not by flush.

Simultaneous events:
- flush_in beats all handshakes.
- A dn and up transfer in the same cycle in BUSY keeps BUSY.
- In FULL, up_valid_in is ignored because up_ready_out=0.

Decomposition:
Shared package riscv_types:
- pipe_state_t enum {PS_EMPTY, PS_BUSY, PS_FULL}.
- Constant CTRL_W_DEF = $bits(riscv_control_t).
- riscv_control_t gains the rule that an all-zero value means NOP.

One sub-module:
- sat_counter, parametrised by CNT_W, with inputs clk_in, rst_in and inc_in and output count_out.
- It is instantiated twice, once for stall_cnt_out and once for xfer_cnt_out.

Test Plan:
1. Reset mid-stream: load 0xDEADBEEF, then drive rst_in=0 between edges -> dn_valid_out=0 and dn_ctrl_out=0 immediately, counters=0, up_ready_out=1.
2. Streaming with dn_ready_in=1, inputs 0x1, 0x2, 0x3 on consecutive cycles -> each appears one cycle later, back-to-back; xfer_cnt_out=3, stall_cnt_out=0.
3. Backpressure with SKID=1 and dn_ready_in=0, offering A, B, C:
   - A is held on dn_*, B goes into skid, up_ready_out drops after B, and C is held upstream.
   - After raising dn_ready_in, the output order is A, B, C, and stall_cnt_out equals the number of stalled cycles.
4. Flush in FULL with up_valid_in=1 and ctrl=0x7FF -> next cycle dn_valid_out=0, dn_ctrl_out=0, up_ready_out=1; the upstream word never appears.
5. SKID=0 configuration: toggle dn_ready_in randomly for 200 cycles -> up_ready_out always equals dn_ready_in | ~dn_valid_out, and the output sequence equals the input sequence.
6. Saturation with CNT_W=4: hold dn_ready_in=0 with a valid word for 20 cycles -> stall_cnt_out reaches 15 and stays at 15.
